// File: rtl/motor_pkg.sv
// Shared definitions for the stepper phase driver.
// Build option: HALF_STEP_EN selects the 8-entry half-step sequence.
package motor_pkg;

    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_CW   = 2'b01;
    localparam logic [1:0] CMD_CCW  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN_CW,
        ST_RUN_CCW,
        ST_REV_WAIT
    } state_t;

    localparam logic [15:0] FULL_PAT = {
        4'b1001, 4'b1100, 4'b0110, 4'b0011
    };

    localparam logic [31:0] HALF_PAT = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

`ifdef HALF_STEP_EN
    localparam int NPH     = 8;
    localparam int MOD_MUL = 2;
`else
    localparam int NPH     = 4;
    localparam int MOD_MUL = 1;
`endif

    localparam int PH_W = 3;

    function automatic logic [3:0] coil_pat(input logic [PH_W-1:0] idx);
        logic [3:0] pat;
        pat = 4'b0000;
`ifdef HALF_STEP_EN
        case (idx)
            3'd0:    pat = HALF_PAT[3:0];
            3'd1:    pat = HALF_PAT[7:4];
            3'd2:    pat = HALF_PAT[11:8];
            3'd3:    pat = HALF_PAT[15:12];
            3'd4:    pat = HALF_PAT[19:16];
            3'd5:    pat = HALF_PAT[23:20];
            3'd6:    pat = HALF_PAT[27:24];
            default: pat = HALF_PAT[31:28];
        endcase
`else
        case (idx)
            3'd0:    pat = FULL_PAT[3:0];
            3'd1:    pat = FULL_PAT[7:4];
            3'd2:    pat = FULL_PAT[11:8];
            3'd3:    pat = FULL_PAT[15:12];
            default: pat = 4'b0000;
        endcase
`endif
        return pat;
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// Prescaler producing a one-cycle tick every DIV enabled cycles.
// Clear has priority over enable and restarts the count at zero.
module divisor_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_tick = i_en & ~i_clr & (r_cnt == LAST);

endmodule

// File: rtl/driver_motor_paso.sv
// Stepper phase driver: tick-paced run/reverse FSM, coil sequencer, position count.
// Build option: HALF_STEP_EN (half-step table, position counts half-steps).
module driver_motor_paso
    import motor_pkg::*;
#(
    parameter int CLK_DIV       = 50000,
    parameter int STEPS_PER_REV = 200,
    parameter int HOLD_TICKS    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  cmd,
    output logic [3:0]  coils,
    output logic [15:0] pos,
    output logic        step_pulse,
    output logic        busy
);

    localparam int MOD = MOD_MUL * STEPS_PER_REV;
    localparam int HW  = $clog2(HOLD_TICKS + 1);
    localparam logic [15:0]     POS_MAX  = 16'(MOD - 1);
    localparam logic [PH_W-1:0] PH_MAX   = PH_W'(NPH - 1);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(HOLD_TICKS);

    state_t          r_state;
    logic [PH_W-1:0] r_phase;
    logic [15:0]     r_pos;
    logic [3:0]      r_coils;
    logic            r_pulse;
    logic [HW-1:0]   r_hold;

    state_t          w_state_n;
    logic [PH_W-1:0] w_phase_n;
    logic [15:0]     w_pos_n;
    logic [3:0]      w_coils_n;
    logic            w_pulse_n;
    logic [HW-1:0]   w_hold_n;
    logic            w_tick;
    logic            w_go_cw;
    logic            w_go_ccw;
    logic            w_release;
    logic [PH_W-1:0] w_ph_inc;
    logic [PH_W-1:0] w_ph_dec;
    logic [15:0]     w_pos_inc;
    logic [15:0]     w_pos_dec;

    divisor_tick #(
        .DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (enable),
        .i_clr  (~enable),
        .o_tick (w_tick)
    );

    always_comb begin
        w_ph_inc  = (r_phase == PH_MAX) ? '0 : r_phase + PH_W'(1);
        w_ph_dec  = (r_phase == '0) ? PH_MAX : r_phase - PH_W'(1);
        w_pos_inc = (r_pos == POS_MAX) ? '0 : r_pos + 16'd1;
        w_pos_dec = (r_pos == '0) ? POS_MAX : r_pos - 16'd1;
    end

    // Next-state decode; cmd only matters on tick cycles
    always_comb begin
        w_state_n = r_state;
        w_hold_n  = r_hold;
        w_go_cw   = 1'b0;
        w_go_ccw  = 1'b0;
        w_release = 1'b0;
        if (!enable) begin
            w_state_n = ST_IDLE;
            w_hold_n  = '0;
            w_release = 1'b1;
        end else if (w_tick) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (cmd == CMD_CW) begin
                        w_state_n = ST_RUN_CW;
                        w_go_cw   = 1'b1;
                    end else if (cmd == CMD_CCW) begin
                        w_state_n = ST_RUN_CCW;
                        w_go_ccw  = 1'b1;
                    end else if (r_hold != HOLD_MAX) begin
                        w_hold_n  = r_hold + HW'(1);
                        w_release = (r_hold + HW'(1)) == HOLD_MAX;
                    end
                end
                ST_RUN_CW: begin
                    if (cmd == CMD_CW) begin
                        w_go_cw = 1'b1;
                    end else if (cmd == CMD_CCW) begin
                        w_state_n = ST_REV_WAIT;
                    end else begin
                        w_state_n = ST_IDLE;
                        w_hold_n  = '0;
                    end
                end
                ST_RUN_CCW: begin
                    if (cmd == CMD_CCW) begin
                        w_go_ccw = 1'b1;
                    end else if (cmd == CMD_CW) begin
                        w_state_n = ST_REV_WAIT;
                    end else begin
                        w_state_n = ST_IDLE;
                        w_hold_n  = '0;
                    end
                end
                ST_REV_WAIT: begin
                    if (cmd == CMD_CW) begin
                        w_state_n = ST_RUN_CW;
                        w_go_cw   = 1'b1;
                    end else if (cmd == CMD_CCW) begin
                        w_state_n = ST_RUN_CCW;
                        w_go_ccw  = 1'b1;
                    end else begin
                        w_state_n = ST_IDLE;
                        w_hold_n  = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_phase_n = r_phase;
        w_pos_n   = r_pos;
        w_coils_n = r_coils;
        w_pulse_n = w_go_cw | w_go_ccw;
        if (w_go_cw) begin
            w_phase_n = w_ph_inc;
            w_pos_n   = w_pos_inc;
            w_coils_n = coil_pat(w_ph_inc);
        end else if (w_go_ccw) begin
            w_phase_n = w_ph_dec;
            w_pos_n   = w_pos_dec;
            w_coils_n = coil_pat(w_ph_dec);
        end else if (w_release) begin
            w_coils_n = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_pos   <= '0;
            r_coils <= '0;
            r_pulse <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_n;
            r_phase <= w_phase_n;
            r_pos   <= w_pos_n;
            r_coils <= w_coils_n;
            r_pulse <= w_pulse_n;
            r_hold  <= w_hold_n;
        end
    end

    assign coils      = r_coils;
    assign pos        = r_pos;
    assign step_pulse = r_pulse;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_driver_motor_paso.sv
// Scoreboard bench for driver_motor_paso (CLK_DIV=4, STEPS_PER_REV=8, HOLD_TICKS=2).
// Build option: HALF_STEP_EN runs the half-step walk instead of the full-step plan.
module tb_driver_motor_paso;

    localparam int CLK_DIV = 4;
    localparam int SPR     = 8;
    localparam int HOLD    = 2;

`ifdef HALF_STEP_EN
    localparam int MODB = 2 * SPR;
`else
    localparam int MODB = SPR;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic [3:0]  coils;
    logic [15:0] pos;
    logic        step_pulse;
    logic        busy;

    typedef struct packed {
        logic [3:0]  coils;
        logic [15:0] pos;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int failures = 0;

    driver_motor_paso #(
        .CLK_DIV       (CLK_DIV),
        .STEPS_PER_REV (SPR),
        .HOLD_TICKS    (HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cmd        (cmd),
        .coils      (coils),
        .pos        (pos),
        .step_pulse (step_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Phase index tracks pos modulo the table length from reset
    function automatic logic [3:0] exp_pat(input int p);
`ifdef HALF_STEP_EN
        case (p % 8)
            0: return 4'b0001;
            1: return 4'b0011;
            2: return 4'b0010;
            3: return 4'b0110;
            4: return 4'b0100;
            5: return 4'b1100;
            6: return 4'b1000;
            default: return 4'b1001;
        endcase
`else
        case (p % 4)
            0: return 4'b0011;
            1: return 4'b0110;
            2: return 4'b1100;
            default: return 4'b1001;
        endcase
`endif
    endfunction

    function automatic void push_step(input int p);
        q.push_back('{coils: exp_pat(p), pos: 16'(p)});
    endfunction

    always @(negedge clk) begin
        if (rst_n && step_pulse) begin
            if (q.size() == 0) begin
                check("unexpected_step", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("step_coils", 32'(coils), 32'(e.coils));
                check("step_pos", 32'(pos), 32'(e.pos));
            end
        end
    end

    task automatic tick_cmd(input logic [1:0] c);
        cmd = c;
        repeat (CLK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic tick_step(input logic [1:0] c, input int p);
        push_step(p);
        tick_cmd(c);
    endtask

    task automatic first_step(input int p);
        int n;
        n = 0;
        enable = 1'b1;
        cmd = 2'b01;
        push_step(p);
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!step_pulse && n < 20);
        check("first_latency", 32'(n), 32'(CLK_DIV));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_coils"}, 32'(coils), 32'd0);
        check({tag, "_pos"}, 32'(pos), 32'd0);
        check({tag, "_step"}, 32'(step_pulse), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        first_step(1);
        check("run_busy", 32'(busy), 32'd1);
`ifdef HALF_STEP_EN
        for (int i = 2; i <= 16; i++) begin
            tick_step(2'b01, i % MODB);
        end
        check("half_wrap_pos", 32'(pos), 32'd0);
`else
        for (int i = 2; i <= 8; i++) begin
            tick_step(2'b01, i % MODB);
        end
        check("wrap_pos", 32'(pos), 32'd0);

        tick_cmd(2'b11);
        check("rev_step", 32'(step_pulse), 32'd0);
        check("rev_busy", 32'(busy), 32'd1);
        check("rev_coils", 32'(coils), 32'b0011);
        tick_step(2'b11, 7);
        tick_step(2'b11, 6);

        tick_cmd(2'b00);
        check("stop_step", 32'(step_pulse), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
        check("hold0_coils", 32'(coils), 32'b1100);
        tick_cmd(2'b00);
        check("hold1_coils", 32'(coils), 32'b1100);
        tick_cmd(2'b00);
        check("hold2_coils", 32'(coils), 32'd0);
        tick_step(2'b01, 7);
        check("reenergize_busy", 32'(busy), 32'd1);

        tick_step(2'b01, 0);
        tick_cmd(2'b00);
        tick_step(2'b11, 7);
        tick_step(2'b11, 6);
        tick_cmd(2'b10);
        check("rsvd_busy", 32'(busy), 32'd0);
        check("rsvd_pos", 32'(pos), 32'd6);

        cmd = 2'b01;
        repeat (2) @(posedge clk);
        cmd = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("glitch_step", 32'(step_pulse), 32'd0);
        check("glitch_pos", 32'(pos), 32'd6);

        tick_step(2'b01, 7);
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("dis_coils", 32'(coils), 32'd0);
        check("dis_busy", 32'(busy), 32'd0);
        check("dis_pos", 32'(pos), 32'd7);
        repeat (3) @(posedge clk);
        #1;
        first_step(0);

        tick_step(2'b01, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        first_step(1);
`endif
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
